// File: rtl/multiplier_n_if.sv
// multiplier_n_if -- handshake/data bundle for the shift-add multiplier.
//
// Signals:
//   ClearA_LoadB  level request: load B from Din and clear A/X (when idle)
//   Execute       level request: start one multiplication (when idle)
//   Din           operand input (multiplier on load, multiplicand on start)
//   Aval, Bval    product high / low halves
//   X             sign-extension bit of {A,B}
//   Busy, Done    status: iterating / result held
//   Ovf           product does not fit WIDTH signed bits (only with MULT_OVF_EN)
//
// Modports: master drives the requests and Din, slave is the multiplier.
// Optional feature macro: MULT_OVF_EN adds the Ovf signal.
interface multiplier_n_if #(
    parameter int WIDTH = 8
);
    logic             ClearA_LoadB;
    logic             Execute;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             X;
    logic             Busy;
    logic             Done;
`ifdef MULT_OVF_EN
    logic             Ovf;

    modport master (
        output ClearA_LoadB, Execute, Din,
        input  Aval, Bval, X, Busy, Done, Ovf
    );
    modport slave (
        input  ClearA_LoadB, Execute, Din,
        output Aval, Bval, X, Busy, Done, Ovf
    );
`else
    modport master (
        output ClearA_LoadB, Execute, Din,
        input  Aval, Bval, X, Busy, Done
    );
    modport slave (
        input  ClearA_LoadB, Execute, Din,
        output Aval, Bval, X, Busy, Done
    );
`endif
endinterface

// File: rtl/multiplier_n.sv
// multiplier_n -- parametrised signed shift-add multiplier, one iteration
// per clock. Product of signed(M) x signed(B at start) ends up in {A,B},
// with X the sign-extension bit. The low half of a finished product stays
// in B and serves as the multiplier of the next run.
//
// Ports:
//   Clk      system clock, rising edge
//   Reset_n  asynchronous active-low reset
//   bus      multiplier_n_if.slave (requests, Din, Aval/Bval/X, Busy/Done[/Ovf])
//
// Optional feature macro: MULT_OVF_EN adds the Ovf overflow flag.
module multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    multiplier_n_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] b_q, b_d;
    logic signed [WIDTH-1:0] m_q, m_d;
    logic                    x_q, x_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    last_iter;
    logic signed [WIDTH:0]   addend;
    logic signed [WIDTH:0]   sum;

    function automatic logic signed [WIDTH:0] sext(input logic signed [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    // The top multiplier bit carries negative weight, so the final iteration
    // subtracts. Negation is done at WIDTH+1 bits so -(-2^(WIDTH-1)) is exact.
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign addend    = b_q[0] ? (last_iter ? -sext(m_q) : sext(m_q)) : '0;
    assign sum       = sext(a_q) + addend;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // Load wins over start when both are requested.
                if (bus.ClearA_LoadB) begin
                    b_d = bus.Din;
                    a_d = '0;
                    x_d = 1'b0;
                end else if (bus.Execute) begin
                    m_d     = bus.Din;
                    a_d     = '0;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d   = sum[WIDTH];
                a_d   = sum[WIDTH:1];
                b_d   = {sum[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                // Wait for Execute to drop so a held request runs only once.
                if (!bus.Execute) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Aval = a_q;
    assign bus.Bval = b_q;
    assign bus.X    = x_q;
    assign bus.Busy = (state_q == RUN);
    assign bus.Done = (state_q == DONE);

`ifdef MULT_OVF_EN
    // Product fits WIDTH signed bits only if A is pure sign extension of B.
    assign bus.Ovf = (state_q == DONE) && (a_q != {WIDTH{b_q[WIDTH-1]}});
`endif

endmodule

// File: tb/tb_multiplier_n.sv
// tb_multiplier_n -- directed-vector bench for multiplier_n (WIDTH=8 and
// WIDTH=16 instances). Ovf is checked only when MULT_OVF_EN is defined.
module tb_multiplier_n;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    multiplier_n_if #(.WIDTH(8))  bus8  ();
    multiplier_n_if #(.WIDTH(16)) bus16 ();

    multiplier_n #(.WIDTH(8))  dut8  (.Clk(clk), .Reset_n(rst_n), .bus(bus8.slave));
    multiplier_n #(.WIDTH(16)) dut16 (.Clk(clk), .Reset_n(rst_n), .bus(bus16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [7:0]  m;
        logic [15:0] prod;
        logic        x;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load8(input logic [7:0] b, input string tag);
        @(negedge clk);
        bus8.ClearA_LoadB = 1'b1;
        bus8.Din          = b;
        @(negedge clk);
        bus8.ClearA_LoadB = 1'b0;
        chk({tag, "_loadB"}, 32'(bus8.Bval), 32'(b));
        chk({tag, "_loadA"}, 32'(bus8.Aval), 32'h0);
    endtask

    // Starts a multiplication, optionally pulses ClearA_LoadB mid-run, holds
    // Execute for `hold` cycles in DONE, then releases it.
    task automatic run8(input logic [7:0] m, input logic [15:0] exp_prod,
                        input logic exp_x, input logic exp_ovf,
                        input int hold, input int pulse_at, input string tag);
        int  busy_cnt;
        int  hold_bad;
        bit  got_done;
        busy_cnt = 0;
        hold_bad = 0;
        got_done = 1'b0;
        @(negedge clk);
        bus8.Execute = 1'b1;
        bus8.Din     = m;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus8.Done) begin
                got_done = 1'b1;
                break;
            end
            if (bus8.Busy) begin
                busy_cnt++;
                bus8.Din = ~m;
            end
            bus8.ClearA_LoadB = (pulse_at >= 0 && busy_cnt == pulse_at);
        end
        bus8.ClearA_LoadB = 1'b0;
        if (!got_done) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout actual=no_done expected=done", tag);
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, "_prod"}, {16'h0, bus8.Aval, bus8.Bval}, {16'h0, exp_prod});
        chk({tag, "_x"}, 32'(bus8.X), 32'(exp_x));
        chk({tag, "_busy_in_done"}, 32'(bus8.Busy), 32'h0);
`ifdef MULT_OVF_EN
        chk({tag, "_ovf"}, 32'(bus8.Ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unexpected x in ovf");
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus8.Done || bus8.Busy || {bus8.Aval, bus8.Bval} !== exp_prod) hold_bad++;
        end
        chk({tag, "_hold_stable"}, 32'(hold_bad), 32'h0);
        bus8.Execute = 1'b0;
        @(negedge clk);
        chk({tag, "_done_released"}, 32'(bus8.Done), 32'h0);
        chk({tag, "_idle_after"}, 32'(bus8.Busy), 32'h0);
    endtask

    initial begin
        int cnt16;
        bit done16;
        checks   = 0;
        failures = 0;

        // b, m, product, X, Ovf
        vecs[0] = '{8'h07, 8'hC5, 16'hFE63, 1'b1, 1'b1};
        vecs[1] = '{8'h80, 8'h80, 16'h4000, 1'b0, 1'b1};
        vecs[2] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{8'h05, 8'h03, 16'h000F, 1'b0, 1'b0};
        vecs[5] = '{8'hFD, 8'h04, 16'hFFF4, 1'b1, 1'b0};
        vecs[6] = '{8'h02, 8'h81, 16'hFF02, 1'b1, 1'b1};

        bus8.ClearA_LoadB  = 1'b0;
        bus8.Execute       = 1'b0;
        bus8.Din           = '0;
        bus16.ClearA_LoadB = 1'b0;
        bus16.Execute      = 1'b0;
        bus16.Din          = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_A", 32'(bus8.Aval), 32'h0);
        chk("reset_B", 32'(bus8.Bval), 32'h0);
        chk("reset_status", {29'h0, bus8.X, bus8.Busy, bus8.Done}, 32'h0);
`ifdef MULT_OVF_EN
        chk("reset_ovf", 32'(bus8.Ovf), 32'h0);
`endif
        rst_n = 1'b1;

        // Test-plan case followed by a consecutive run reusing B=0x63.
        load8(8'h07, "tp");
        run8(8'hC5, 16'hFE63, 1'b1, 1'b1, 1, -1, "tp");
        run8(8'h02, 16'h00C6, 1'b0, 1'b1, 1, -1, "consec");

        for (int i = 0; i < 7; i++) begin
            load8(vecs[i].b, $sformatf("v%0d", i));
            run8(vecs[i].m, vecs[i].prod, vecs[i].x, vecs[i].ovf, 1, -1, $sformatf("v%0d", i));
        end

        // Execute held 50 cycles: one run only.
        load8(8'h05, "hold");
        run8(8'h03, 16'h000F, 1'b0, 1'b0, 50, -1, "hold");

        // Load and Execute together in IDLE: load only.
        @(negedge clk);
        bus8.ClearA_LoadB = 1'b1;
        bus8.Execute      = 1'b1;
        bus8.Din          = 8'h33;
        @(negedge clk);
        bus8.ClearA_LoadB = 1'b0;
        bus8.Execute      = 1'b0;
        chk("both_busy", 32'(bus8.Busy), 32'h0);
        chk("both_B", 32'(bus8.Bval), 32'h33);
        @(negedge clk);
        chk("both_no_run", {30'h0, bus8.Busy, bus8.Done}, 32'h0);

        // ClearA_LoadB pulsed mid-run is ignored.
        load8(8'hFD, "pulse");
        run8(8'h04, 16'hFFF4, 1'b1, 1'b0, 1, 3, "pulse");

        // Asynchronous reset after four iterations.
        load8(8'h07, "rst");
        @(negedge clk);
        bus8.Execute = 1'b1;
        bus8.Din     = 8'hC5;
        repeat (5) @(negedge clk);
        chk("rst_midrun_busy", 32'(bus8.Busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_AB", {16'h0, bus8.Aval, bus8.Bval}, 32'h0);
        chk("rst_async_status", {29'h0, bus8.X, bus8.Busy, bus8.Done}, 32'h0);
        bus8.Execute = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stays_idle", {30'h0, bus8.Busy, bus8.Done}, 32'h0);
        load8(8'h7F, "after_rst");
        run8(8'h7F, 16'h3F01, 1'b0, 1'b1, 1, -1, "after_rst");

        // WIDTH=16: -1 x -32768.
        @(negedge clk);
        bus16.ClearA_LoadB = 1'b1;
        bus16.Din          = 16'hFFFF;
        @(negedge clk);
        bus16.ClearA_LoadB = 1'b0;
        bus16.Execute      = 1'b1;
        bus16.Din          = 16'h8000;
        cnt16  = 0;
        done16 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus16.Done) begin
                done16 = 1'b1;
                break;
            end
            if (bus16.Busy) cnt16++;
        end
        if (!done16) begin
            failures++;
            checks++;
            $display("FAIL w16_timeout actual=no_done expected=done");
        end
        chk("w16_busy_cycles", 32'(cnt16), 32'd16);
        chk("w16_prod", {bus16.Aval, bus16.Bval}, 32'h0000_8000);
        chk("w16_x", 32'(bus16.X), 32'h0);
`ifdef MULT_OVF_EN
        chk("w16_ovf", 32'(bus16.Ovf), 32'h1);
`endif
        bus16.Execute = 1'b0;
        @(negedge clk);
        chk("w16_released", 32'(bus16.Done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
